// File: rtl/cmsdk_uart_stim.sv
// cmsdk_uart_stim: byte FIFO feeding a UART transmitter, used to drive an MCU RXD pin.
// Frames are 8N1 by default; defining CMSDK_UART_STIM_PARITY_EN adds an even parity bit.
module cmsdk_uart_stim #(
  parameter int BAUDDIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       TX_EN,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       TXD,
  output logic       BUSY,
  output logic [4:0] FIFO_LEVEL
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_RELOAD = 16'(BAUDDIV - 1);
  localparam logic [4:0]  LEVEL_FULL = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef CMSDK_UART_STIM_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic            txd, txd_nxt;
  logic [7:0]      shift;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      level;
  logic            push, pop;

  assign DATA_READY = (level != LEVEL_FULL);
  assign push       = DATA_VALID && DATA_READY;
  assign TXD        = txd;
  assign FIFO_LEVEL = level;
  assign BUSY       = (state != IDLE) || (level != 5'd0);

  // Frame sequencer: picks the next state, bit timer value and registered line level.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    txd_nxt     = txd;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (TX_EN && (level != 5'd0)) begin
          pop         = 1'b1;
          state_nxt   = START;
          cnt_nxt     = BIT_RELOAD;
          bit_idx_nxt = 3'd0;
          txd_nxt     = 1'b0;
        end
      end
      START: begin
        if (cnt == 16'd0) begin
          state_nxt   = DATA;
          cnt_nxt     = BIT_RELOAD;
          bit_idx_nxt = 3'd0;
          txd_nxt     = shift[0];
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          cnt_nxt = BIT_RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef CMSDK_UART_STIM_PARITY_EN
            state_nxt = PARITY;
            txd_nxt   = ^shift;
`else
            state_nxt = STOP;
            txd_nxt   = 1'b1;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = shift[bit_idx_nxt];
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
`ifdef CMSDK_UART_STIM_PARITY_EN
      PARITY: begin
        if (cnt == 16'd0) begin
          state_nxt = STOP;
          cnt_nxt   = BIT_RELOAD;
          txd_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt == 16'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
          txd_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = 16'd0;
        bit_idx_nxt = 3'd0;
        txd_nxt     = 1'b1;
      end
    endcase
  end

  // Sequencer registers; reset parks the line high in IDLE.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      txd     <= txd_nxt;
    end
  end

  // Head byte is captured into the shift register on the same edge it leaves the FIFO.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      shift <= 8'd0;
    end else if (pop) begin
      shift <= mem[rd_ptr];
    end
  end

  // FIFO storage needs no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= DATA_IN;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; level tracks push minus pop.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

endmodule
